// File: rtl/mips_avalon_pkg.sv
// rtl/mips_avalon_pkg.sv - shared types and constants for the MIPS Avalon master
package mips_avalon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_SETTLE,
        ST_RESP,
        ST_ERR
    } avm_state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteenable;
    } avm_req_t;

    localparam logic [1:0] AVM_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mips_avalon_wait_ctr.sv
// rtl/mips_avalon_wait_ctr.sv - saturating wait-cycle counter with clear and enable
module mips_avalon_wait_ctr #(
    parameter int CTR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    output logic [CTR_WIDTH-1:0] count
);

    // Clear wins over enable; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {CTR_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_avalon_master.sv
// rtl/mips_avalon_master.sv - CPU request to Avalon-MM master; optional abort via MIPS_AVM_TIMEOUT_EN
module mips_avalon_master
    import mips_avalon_pkg::*;
#(
    parameter int CTR_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_req_valid,
    output logic                 cpu_req_ready,
    input  logic                 cpu_req_write,
    input  logic [31:0]          cpu_req_addr,
    input  logic [31:0]          cpu_req_wdata,
    input  logic [3:0]           cpu_req_byteenable,
    output logic                 cpu_resp_valid,
    output logic [31:0]          cpu_resp_rdata,
    output logic                 cpu_resp_err,
    output logic [31:0]          address,
    output logic                 read,
    output logic                 write,
    output logic [31:0]          writedata,
    output logic [3:0]           byteenable,
    input  logic                 waitrequest,
    input  logic [31:0]          readdata,
    output logic [CTR_WIDTH-1:0] last_wait_cycles
);

`ifdef MIPS_AVM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [CTR_WIDTH-1:0] TO_LIMIT = CTR_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] TO_VALUE = CTR_WIDTH'(TIMEOUT_CYCLES);

    avm_state_t           state;
    avm_state_t           state_next;
    avm_req_t             req;
    logic                 ctr_clr;
    logic                 ctr_en;
    logic [CTR_WIDTH-1:0] wait_count;
    logic                 misaligned;
    logic                 timeout_hit;
    logic                 bus_active;

    assign misaligned  = (cpu_req_addr[1:0] & AVM_ALIGN_MASK) != 2'b00;
    // This wait cycle is the one that brings the counter up to the limit.
    assign timeout_hit = TO_EN && waitrequest && (wait_count == TO_LIMIT);

    mips_avalon_wait_ctr #(
        .CTR_WIDTH(CTR_WIDTH)
    ) u_wait_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (ctr_clr),
        .en   (ctr_en),
        .count(wait_count)
    );

    // State register; reset returns to IDLE at once, which drops read/write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and counter control.
    always_comb begin
        state_next = state;
        ctr_clr    = 1'b0;
        ctr_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cpu_req_valid) begin
                    ctr_clr    = 1'b1;
                    state_next = misaligned ? ST_ERR : ST_CMD;
                end
            end
            ST_CMD: begin
                if (waitrequest) begin
                    ctr_en = 1'b1;
                    if (timeout_hit) begin
                        state_next = ST_ERR;
                    end
                end else begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            ST_ERR:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Request latch, read-data capture and wait-count publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req              <= '0;
            cpu_resp_rdata   <= '0;
            last_wait_cycles <= '0;
        end else begin
            if ((state == ST_IDLE) && cpu_req_valid) begin
                req.write      <= cpu_req_write;
                req.addr       <= cpu_req_addr;
                req.wdata      <= cpu_req_wdata;
                req.byteenable <= cpu_req_write ? cpu_req_byteenable : 4'hF;
            end
            if (state == ST_SETTLE) begin
                last_wait_cycles <= wait_count;
                if (!req.write) begin
                    cpu_resp_rdata <= readdata;
                end
            end
            if ((state == ST_CMD) && timeout_hit) begin
                last_wait_cycles <= TO_VALUE;
            end
        end
    end

    // Bus strobes cover CMD and the settle cycle; fields come straight from the latch.
    assign bus_active     = (state == ST_CMD) || (state == ST_SETTLE);
    assign read           = bus_active && !req.write;
    assign write          = bus_active && req.write;
    assign address        = req.addr;
    assign writedata      = req.wdata;
    assign byteenable     = req.byteenable;
    assign cpu_req_ready  = (state == ST_IDLE) && rst_n;
    assign cpu_resp_valid = (state == ST_RESP) || (state == ST_ERR);
    assign cpu_resp_err   = (state == ST_ERR);

endmodule

// File: tb/tb_mips_avalon_master.sv
// tb/tb_mips_avalon_master.sv - scoreboard bench for mips_avalon_master
module tb_mips_avalon_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_write;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic [3:0]  cpu_req_byteenable;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        cpu_resp_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [15:0] last_wait_cycles;

    always #5 clk = ~clk;

    mips_avalon_master #(
        .CTR_WIDTH(16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cpu_req_valid     (cpu_req_valid),
        .cpu_req_ready     (cpu_req_ready),
        .cpu_req_write     (cpu_req_write),
        .cpu_req_addr      (cpu_req_addr),
        .cpu_req_wdata     (cpu_req_wdata),
        .cpu_req_byteenable(cpu_req_byteenable),
        .cpu_resp_valid    (cpu_resp_valid),
        .cpu_resp_rdata    (cpu_resp_rdata),
        .cpu_resp_err      (cpu_resp_err),
        .address           (address),
        .read              (read),
        .write             (write),
        .writedata         (writedata),
        .byteenable        (byteenable),
        .waitrequest       (waitrequest),
        .readdata          (readdata),
        .last_wait_cycles  (last_wait_cycles)
    );

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          waits;
        int          bus;
        logic [31:0] addr;
        bit          wr;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit err, input logic [31:0] rdata, input int lat,
                                input int waits, input int bus, input logic [31:0] addr,
                                input bit wr);
        exp_t e;
        e.err = err; e.rdata = rdata; e.lat = lat; e.waits = waits;
        e.bus = bus; e.addr = addr; e.wr = wr;
        return e;
    endfunction

    // Slave model: waitrequest high for sl_delay cycles of each transaction.
    logic [31:0] mem [16];
    int          sl_delay = 0;
    bit          stuck = 1'b0;
    int          wcnt = 0;

    function automatic int idx(input logic [31:0] a);
        return int'({a[5] ^ a[31], a[4:2]});
    endfunction

    assign waitrequest = stuck ? 1'b1 : ((read || write) && (wcnt < sl_delay));
    assign readdata    = mem[idx(address)];

    always @(posedge clk) begin
        logic [31:0] merged;
        if (read || write) begin
            if (waitrequest) wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
        if (write && !waitrequest) begin
            merged = mem[idx(address)];
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) merged[8*b +: 8] = writedata[8*b +: 8];
            mem[idx(address)] <= merged;
        end
    end

    // Monitor: bus protocol checks and scoreboard pops on each response.
    int          cyc = 0;
    int          accept_cyc = 0;
    int          high_cnt = 0;
    int          gap = 100;
    bit          prev_bus = 1'b0;
    logic [31:0] snap_addr;
    logic [31:0] snap_wd;
    logic [3:0]  snap_be;
    bit          snap_wr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            high_cnt = 0;
            prev_bus = 1'b0;
            gap      = 100;
        end else begin
            if (cpu_req_valid && cpu_req_ready) accept_cyc = cyc + 1;
            if (read || write) begin
                chk("rd_wr_excl", read & write, 0);
                if (!prev_bus) begin
                    chk("bus_gap", gap >= 1, 1);
                    snap_addr = address; snap_wd = writedata;
                    snap_be = byteenable; snap_wr = write;
                end else begin
                    chk("addr_stable", address, snap_addr);
                    chk("wdata_stable", writedata, snap_wd);
                    chk("be_stable", byteenable, snap_be);
                    chk("dir_stable", write, snap_wr);
                end
                high_cnt++;
                gap      = 0;
                prev_bus = 1'b1;
            end else begin
                gap++;
                prev_bus = 1'b0;
            end
            if (cpu_resp_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected none");
                end else begin
                    e = sbq.pop_front();
                    chk("resp_err", cpu_resp_err, e.err);
                    chk("resp_rdata", cpu_resp_rdata, e.rdata);
                    chk("latency", (cyc + 1) - accept_cyc, e.lat);
                    chk("last_wait", last_wait_cycles, e.waits);
                    chk("bus_cycles", high_cnt, e.bus);
                    if (e.bus > 0) begin
                        chk("bus_addr", snap_addr, e.addr);
                        chk("bus_dir", snap_wr, e.wr);
                        if (!e.wr) chk("read_be", snap_be, 4'hF);
                    end
                end
                high_cnt = 0;
            end
        end
    end

    // Present a request and return once it has been accepted; valid stays high.
    task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input exp_t e);
        int n;
        sbq.push_back(e);
        cpu_req_valid      = 1'b1;
        cpu_req_write      = wr;
        cpu_req_addr       = a;
        cpu_req_wdata      = wd;
        cpu_req_byteenable = be;
        n = 0;
        forever begin
            @(negedge clk);
            if (cpu_req_ready || n > 300) break;
            n++;
        end
        if (!cpu_req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no ready after %0d cycles expected ready", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        cpu_req_valid = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA500_0000 | (i * 32'h111);
        rst_n = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_write = 1'b0;
        cpu_req_addr = '0; cpu_req_wdata = '0; cpu_req_byteenable = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", cpu_req_ready, 0);
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_resp_valid", cpu_resp_valid, 0);
        chk("rst_address", address, 0);
        chk("rst_last_wait", last_wait_cycles, 0);
        chk("rst_rdata", cpu_resp_rdata, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", cpu_req_ready, 1);

        // Read with two wait cycles
        sl_delay = 2;
        send(1'b0, 32'hBFC0_0000, 32'h0, 4'h0, mk(0, 32'hA500_0888, 5, 2, 4, 32'hBFC0_0000, 0));
        drain();

        // Write low half, no wait
        sl_delay = 0;
        send(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011,
             mk(0, 32'hA500_0888, 3, 0, 2, 32'h0000_0010, 1));
        drain();
        chk("mem_write_lanes", mem[4], 32'hA500_5678);

        // Read back the written word, one wait cycle
        sl_delay = 1;
        send(1'b0, 32'h0000_0010, 32'h0, 4'h0, mk(0, 32'hA500_5678, 4, 1, 3, 32'h0000_0010, 0));
        drain();

        // Misaligned: error in one cycle, no bus access
        send(1'b0, 32'h0000_0006, 32'h0, 4'h0, mk(1, 32'hA500_5678, 1, 1, 0, 32'h0, 0));
        drain();

        // Back-to-back reads with valid held
        sl_delay = 0;
        send(1'b0, 32'h0000_0000, 32'h0, 4'h0, mk(0, 32'hA500_0000, 3, 0, 2, 32'h0000_0000, 0));
        send(1'b0, 32'h0000_0004, 32'h0, 4'h0, mk(0, 32'hA500_0111, 3, 0, 2, 32'h0000_0004, 0));
        drain();

        // Reset asserted while the master waits in CMD
        sl_delay = 6;
        cpu_req_valid = 1'b1; cpu_req_write = 1'b0; cpu_req_addr = 32'h0000_0004;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_read", read, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_read_drop", read, 0);
        chk("async_resp_valid", cpu_resp_valid, 0);
        chk("async_ready", cpu_req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        sl_delay = 0;
        send(1'b0, 32'h0000_0008, 32'h0, 4'h0, mk(0, 32'hA500_0222, 3, 0, 2, 32'h0000_0008, 0));
        drain();

`ifdef MIPS_AVM_TIMEOUT_EN
        // Slave never releases waitrequest
        stuck = 1'b1;
        send(1'b0, 32'h0000_000C, 32'h0, 4'h0, mk(1, 32'hA500_0222, 9, 8, 8, 32'h0000_000C, 0));
        drain();
        stuck = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_avalon_master.md
Name: mips_avalon_master

Overview:
Avalon memory-mapped master that turns single CPU-side memory requests into Avalon read/write transactions. It sits between the MIPS core's fetch/load-store logic and the system memory slaves. Bus signals are held stable for the whole transaction, including the settle cycle the memory requires after waitrequest falls. It returns one response per request and counts wait cycles.

Parameters:
CTR_WIDTH, 16, width of the wait-cycle counter and the last_wait_cycles output (saturating).
TIMEOUT_CYCLES, 256, waitrequest-high cycles before abort; used only when MIPS_AVM_TIMEOUT_EN is defined.

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
cpu_req_valid  in  1  CPU request present; requester holds it and the fields until accepted
cpu_req_ready  out  1  master can accept; high only in IDLE
cpu_req_write  in  1  1=write, 0=read
cpu_req_addr  in  32  byte address, must be word-aligned
cpu_req_wdata  in  32  write data
cpu_req_byteenable  in  4  write byte lanes
cpu_resp_valid  out  1  one-cycle response strobe
cpu_resp_rdata  out  32  read data, valid with cpu_resp_valid on reads
cpu_resp_err  out  1  response is an error (misaligned, or timeout)
address  out  32  Avalon address
read  out  1  Avalon read
write  out  1  Avalon write
writedata  out  32  Avalon write data
byteenable  out  4  Avalon byte enables (4'hF on reads)
waitrequest  in  1  Avalon wait
readdata  in  32  Avalon read data
last_wait_cycles  out  CTR_WIDTH  waitrequest-high cycles of the last completed transaction

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0, including cpu_req_ready (ready=(state==IDLE)&&rst_n); state=IDLE.
  - Reset mid-transaction drops read/write immediately; no response is issued.
- States: IDLE, CMD, SETTLE, RESP, ERR.
- IDLE, on accept (cpu_req_valid&&cpu_req_ready at posedge):
  - Latch address, wdata and byteenable; clear the wait counter.
  - If cpu_req_addr[1:0]!=0, go to ERR. No bus access occurs.
  - Otherwise go to CMD, with read or write registered high from the next cycle.
- CMD: address, writedata, byteenable and read/write are constant.
  - Each cycle with waitrequest=1: stay and increment the counter (saturating at all-ones).
  - First cycle with waitrequest=0: go to SETTLE.
- SETTLE: read/write is still asserted and all bus fields are unchanged.
  - Reads: capture readdata into cpu_resp_rdata at the end of this cycle.
  - last_wait_cycles<=counter. Go to RESP.
- RESP:
  - read=write=0.
  - cpu_resp_valid=1 and cpu_resp_err=0 for exactly one cycle, then IDLE.
  - cpu_resp_rdata is held until the next read response; writes leave it unchanged.
- ERR: cpu_resp_valid=1 and cpu_resp_err=1 for one cycle, read=write=0, then IDLE.
- read and write are never both high.
- Between bus transactions there is at least one cycle (RESP) with read=write=0.
- Latency from accept edge to resp_valid: 3+N cycles, where N is the number of waitrequest-high cycles. Misaligned requests take 1 cycle.
- cpu_req_valid while not ready is ignored. No queuing.

Optional Feature:
MIPS_AVM_TIMEOUT_EN
- Defined: in CMD, if the counter reaches TIMEOUT_CYCLES with waitrequest still 1, go to ERR. read/write drop in that cycle, and last_wait_cycles<=TIMEOUT_CYCLES.
- Undefined: the master waits indefinitely, and cpu_resp_err is asserted only for misalignment.

Decomposition:
- Package mips_avalon_pkg holds:
  - the state enum (avm_state_t);
  - a request struct (avm_req_t: write, addr, wdata, byteenable);
  - the constant AVM_ALIGN_MASK=2'b11.
- One sub-module, mips_avalon_wait_ctr: saturating counter with clear and enable, parameterised by CTR_WIDTH.

Test Plan:
- Read at 0xBFC00000, slave delay 2 -> read high 4 cycles, resp_valid 5 cycles after accept, rdata=memory word, err=0, last_wait_cycles=2.
- Write 0x12345678 to 0x00000010 with byteenable 4'b0011, delay 0 -> write high 2 cycles, fields stable, memory low half updated, resp_valid with err=0, last_wait_cycles=0.
- Request to 0x00000006 -> no read/write pulse, resp_valid and err=1 one cycle after accept.
- Back-to-back reads to 0x0 and 0x4 with cpu_req_valid held -> one idle bus cycle between transactions, second accepted only in IDLE, two responses in order.
- rst_n pulsed low during CMD -> read=0 asynchronously, no resp_valid, next request after release completes normally.
- MIPS_AVM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and waitrequest stuck high -> read drops and resp_valid with err=1 after 8 wait cycles, last_wait_cycles=8.
